// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub+shift step per RUN cycle, registered result.
// Optional BOOTH_UNSIGNED_MODE_EN adds a tc input selecting signed (tc=1) or unsigned (tc=0) operation.
module booth_mult_seq #(
  parameter int WA = 8,
  parameter int WB = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef BOOTH_UNSIGNED_MODE_EN
  input  logic               tc,
`endif
  input  logic [WA-1:0]      multiplicand,
  input  logic [WB-1:0]      multiplier,
  output logic               busy,
  output logic               done,
  output logic [WA+WB-1:0]   product
);

`ifdef BOOTH_UNSIGNED_MODE_EN
  localparam int EXT = 1;
`else
  localparam int EXT = 0;
`endif
  // Unsigned mode zero-extends both operands by one bit, so the datapath grows by EXT.
  localparam int AW = WA + 1 + EXT;
  localparam int QW = WB + EXT;
  localparam int CW = $clog2(WB + 2);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t              state_r, state_nx;
  logic [AW-1:0]       a_r, a_nx;
  logic [AW-1:0]       acc_r, acc_nx;
  logic [QW-1:0]       q_r, q_nx;
  logic                qm1_r, qm1_nx;
  logic [CW-1:0]       cnt_r, cnt_nx;
  logic [CW-1:0]       last_s;
  logic [AW-1:0]       sum_s;
  logic                busy_r, busy_nx;
  logic                done_r, done_nx;
  logic [WA+WB-1:0]    product_r, product_nx;
`ifdef BOOTH_UNSIGNED_MODE_EN
  logic                tc_r, tc_nx;
`endif

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      a_r       <= {AW{1'b0}};
      acc_r     <= {AW{1'b0}};
      q_r       <= {QW{1'b0}};
      qm1_r     <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {(WA+WB){1'b0}};
`ifdef BOOTH_UNSIGNED_MODE_EN
      tc_r      <= 1'b0;
`endif
    end else begin
      state_r   <= state_nx;
      a_r       <= a_nx;
      acc_r     <= acc_nx;
      q_r       <= q_nx;
      qm1_r     <= qm1_nx;
      cnt_r     <= cnt_nx;
      busy_r    <= busy_nx;
      done_r    <= done_nx;
      product_r <= product_nx;
`ifdef BOOTH_UNSIGNED_MODE_EN
      tc_r      <= tc_nx;
`endif
    end
  end

  // Booth step selection, next-state logic and registered-output next values.
  always_comb begin
    state_nx   = state_r;
    a_nx       = a_r;
    acc_nx     = acc_r;
    q_nx       = q_r;
    qm1_nx     = qm1_r;
    cnt_nx     = cnt_r;
    busy_nx    = busy_r;
    done_nx    = 1'b0;
    product_nx = product_r;
`ifdef BOOTH_UNSIGNED_MODE_EN
    tc_nx      = tc_r;
    last_s     = tc_r ? CW'(WB - 1) : CW'(WB);
`else
    last_s     = CW'(WB - 1);
`endif

    case ({q_r[0], qm1_r})
      2'b01:   sum_s = acc_r + a_r;
      2'b10:   sum_s = acc_r - a_r;
      default: sum_s = acc_r;
    endcase

    case (state_r)
      IDLE: begin
        if (start) begin
`ifdef BOOTH_UNSIGNED_MODE_EN
          a_nx  = {{2{tc & multiplicand[WA-1]}}, multiplicand};
          q_nx  = {tc & multiplier[WB-1], multiplier};
          tc_nx = tc;
`else
          a_nx  = {multiplicand[WA-1], multiplicand};
          q_nx  = multiplier;
`endif
          acc_nx   = {AW{1'b0}};
          qm1_nx   = 1'b0;
          cnt_nx   = {CW{1'b0}};
          busy_nx  = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        acc_nx = {sum_s[AW-1], sum_s[AW-1:1]};
        q_nx   = {sum_s[0], q_r[QW-1:1]};
        qm1_nx = q_r[0];
        cnt_nx = cnt_r + CW'(1);
        if (cnt_r == last_s) begin
          state_nx = DONE;
          done_nx  = 1'b1;
          // A signed run stops one shift short, leaving the spare Q bit below the product.
`ifdef BOOTH_UNSIGNED_MODE_EN
          if (tc_r) begin
            product_nx = {acc_nx[WA-1:0], q_nx[QW-1:1]};
          end else begin
            product_nx = {acc_nx[WA-2:0], q_nx};
          end
`else
          product_nx = {acc_nx[WA-1:0], q_nx};
`endif
        end else begin
          state_nx = RUN;
        end
      end
      DONE: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule
